// File: rtl/msrv_32_pkg.sv
// Shared MSRV32 definitions: datapath widths, write-back selects and the stage-2 register record.
package msrv_32_pkg;

  localparam int XLEN      = 32;
  localparam int INSTRET_W = 64;

  localparam logic [2:0] WB_ALU     = 3'b000;
  localparam logic [2:0] WB_LU      = 3'b001;
  localparam logic [2:0] WB_IMM     = 3'b010;
  localparam logic [2:0] WB_IADDER  = 3'b011;
  localparam logic [2:0] WB_CSR     = 3'b100;
  localparam logic [2:0] WB_PC_PLUS = 3'b101;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_addr;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] iadder;
    logic [XLEN-1:0] imm;
    logic [2:0]      wb_mux_sel;
    logic [3:0]      alu_opcode;
    logic            alu_src;
    logic [1:0]      load_size;
    logic            load_unsigned;
    logic [2:0]      csr_op;
    logic            rf_wr_en;
    logic            csr_wr_en;
  } s2_t;

endpackage

// File: rtl/msrv_32_reg_block_2_if.sv
// Stage-1 to stage-2 bus: captured fields in, registered fields plus retire status out.
interface msrv_32_reg_block_2_if;
  import msrv_32_pkg::*;

  logic                 stall_in;
  logic                 flush_in;
  logic                 valid_in;
  logic [4:0]           rd_addr_in;
  logic [11:0]          csr_addr_in;
  logic [XLEN-1:0]      rs1_in;
  logic [XLEN-1:0]      rs2_in;
  logic [XLEN-1:0]      pc_in;
  logic [XLEN-1:0]      pc_plus_4_in;
  logic [XLEN-1:0]      iadder_in;
  logic [XLEN-1:0]      imm_in;
  logic [2:0]           wb_mux_sel_in;
  logic [3:0]           alu_opcode_in;
  logic                 alu_src_in;
  logic [1:0]           load_size_in;
  logic                 load_unsigned_in;
  logic [2:0]           csr_op_in;
  logic                 rf_wr_en_in;
  logic                 csr_wr_en_in;

  logic                 valid_reg_out;
  logic [4:0]           rd_addr_reg_out;
  logic [11:0]          csr_addr_reg_out;
  logic [XLEN-1:0]      rs1_reg_out;
  logic [XLEN-1:0]      rs2_reg_out;
  logic [XLEN-1:0]      pc_reg_out;
  logic [XLEN-1:0]      pc_plus_4_reg_out;
  logic [XLEN-1:0]      iadder_reg_out;
  logic [XLEN-1:0]      imm_reg_out;
  logic [2:0]           wb_mux_sel_reg_out;
  logic [3:0]           alu_opcode_reg_out;
  logic                 alu_src_reg_out;
  logic [1:0]           load_size_reg_out;
  logic                 load_unsigned_reg_out;
  logic [2:0]           csr_op_reg_out;
  logic                 rf_wr_en_reg_out;
  logic                 csr_wr_en_reg_out;
  logic [INSTRET_W-1:0] instret_out;
  logic                 retire_pulse_out;

  modport master (
    output stall_in, flush_in, valid_in, rd_addr_in, csr_addr_in, rs1_in, rs2_in,
           pc_in, pc_plus_4_in, iadder_in, imm_in, wb_mux_sel_in, alu_opcode_in,
           alu_src_in, load_size_in, load_unsigned_in, csr_op_in, rf_wr_en_in,
           csr_wr_en_in,
    input  valid_reg_out, rd_addr_reg_out, csr_addr_reg_out, rs1_reg_out, rs2_reg_out,
           pc_reg_out, pc_plus_4_reg_out, iadder_reg_out, imm_reg_out,
           wb_mux_sel_reg_out, alu_opcode_reg_out, alu_src_reg_out, load_size_reg_out,
           load_unsigned_reg_out, csr_op_reg_out, rf_wr_en_reg_out, csr_wr_en_reg_out,
           instret_out, retire_pulse_out
  );

  modport slave (
    input  stall_in, flush_in, valid_in, rd_addr_in, csr_addr_in, rs1_in, rs2_in,
           pc_in, pc_plus_4_in, iadder_in, imm_in, wb_mux_sel_in, alu_opcode_in,
           alu_src_in, load_size_in, load_unsigned_in, csr_op_in, rf_wr_en_in,
           csr_wr_en_in,
    output valid_reg_out, rd_addr_reg_out, csr_addr_reg_out, rs1_reg_out, rs2_reg_out,
           pc_reg_out, pc_plus_4_reg_out, iadder_reg_out, imm_reg_out,
           wb_mux_sel_reg_out, alu_opcode_reg_out, alu_src_reg_out, load_size_reg_out,
           load_unsigned_reg_out, csr_op_reg_out, rf_wr_en_reg_out, csr_wr_en_reg_out,
           instret_out, retire_pulse_out
  );

endinterface

// File: rtl/msrv_32_instret_counter.sv
// Free-running 64-bit retired-instruction counter; increments on enable, wraps to zero.
module msrv_32_instret_counter
  import msrv_32_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 en_in,
  output logic [INSTRET_W-1:0] count_out
);

  logic [INSTRET_W-1:0] count_q;
  logic [INSTRET_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_in) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/msrv_32_reg_block_2.sv
// Stage-1/stage-2 pipeline register: holds on stall, loads a bubble on flush (flush wins),
// blocks x0 writes, and counts retirements for minstret.
module msrv_32_reg_block_2
  import msrv_32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
  input  logic                   ms_riscv32_mp_clk_in,
  input  logic                   ms_riscv32_mp_rst_in,
  msrv_32_reg_block_2_if.slave   bus
);

  s2_t  s2_q;
  s2_t  s2_d;
  s2_t  s2_in;
  logic retire;

  always_comb begin
    s2_in               = '0;
    s2_in.valid         = bus.valid_in;
    s2_in.rd_addr       = bus.rd_addr_in;
    s2_in.csr_addr      = bus.csr_addr_in;
    s2_in.rs1           = bus.rs1_in;
    s2_in.rs2           = bus.rs2_in;
    s2_in.pc            = bus.pc_in;
    s2_in.pc_plus_4     = bus.pc_plus_4_in;
    s2_in.iadder        = bus.iadder_in;
    s2_in.imm           = bus.imm_in;
    s2_in.wb_mux_sel    = bus.wb_mux_sel_in;
    s2_in.alu_opcode    = bus.alu_opcode_in;
    s2_in.alu_src       = bus.alu_src_in;
    s2_in.load_size     = bus.load_size_in;
    s2_in.load_unsigned = bus.load_unsigned_in;
    s2_in.csr_op        = bus.csr_op_in;
    // Writes to x0 are dropped here so stage 2 never has to check rd.
    s2_in.rf_wr_en      = bus.rf_wr_en_in & bus.valid_in & (bus.rd_addr_in != 5'd0);
    s2_in.csr_wr_en     = bus.csr_wr_en_in & bus.valid_in;
  end

  always_comb begin
    s2_d = s2_q;
    if (bus.flush_in) begin
      s2_d            = s2_in;
      s2_d.valid      = 1'b0;
      s2_d.rf_wr_en   = 1'b0;
      s2_d.csr_wr_en  = 1'b0;
      s2_d.wb_mux_sel = WB_ALU;
    end else if (!bus.stall_in) begin
      s2_d = s2_in;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      s2_q    <= '0;
      s2_q.pc <= RESET_PC;
    end else begin
      s2_q    <= s2_d;
    end
  end

  // The flush bubble does not stop the instruction already in stage 2 from retiring.
  assign retire = s2_q.valid & ~bus.stall_in;

  msrv_32_instret_counter u_instret (
    .clk_in    (ms_riscv32_mp_clk_in),
    .rst_in    (ms_riscv32_mp_rst_in),
    .en_in     (retire),
    .count_out (bus.instret_out)
  );

  assign bus.retire_pulse_out      = retire;
  assign bus.valid_reg_out         = s2_q.valid;
  assign bus.rd_addr_reg_out       = s2_q.rd_addr;
  assign bus.csr_addr_reg_out      = s2_q.csr_addr;
  assign bus.rs1_reg_out           = s2_q.rs1;
  assign bus.rs2_reg_out           = s2_q.rs2;
  assign bus.pc_reg_out            = s2_q.pc;
  assign bus.pc_plus_4_reg_out     = s2_q.pc_plus_4;
  assign bus.iadder_reg_out        = s2_q.iadder;
  assign bus.imm_reg_out           = s2_q.imm;
  assign bus.wb_mux_sel_reg_out    = s2_q.wb_mux_sel;
  assign bus.alu_opcode_reg_out    = s2_q.alu_opcode;
  assign bus.alu_src_reg_out       = s2_q.alu_src;
  assign bus.load_size_reg_out     = s2_q.load_size;
  assign bus.load_unsigned_reg_out = s2_q.load_unsigned;
  assign bus.csr_op_reg_out        = s2_q.csr_op;
  assign bus.rf_wr_en_reg_out      = s2_q.rf_wr_en;
  assign bus.csr_wr_en_reg_out     = s2_q.csr_wr_en;

endmodule
